// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU clients and the alu_arbiter.
// The master side belongs to the clients/consumer, and the slave side belongs to the arbiter.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [2:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [2:0]        req1_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational 32-bit ALU between two valid/ready requesters.
// Optional feature macro ALU_ARB_ILLEGAL_OP_EN: flags opcodes 011/111 and skips the ALU pass.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_srcA,
    output logic [DATA_W-1:0] alu_srcB,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              prio;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [2:0]        op_ctrl;
    logic              op_id;

    logic              grant_valid;
    logic              grant_id;
    logic              accept;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [2:0]        sel_op;

    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;

    // prio only breaks ties; a lone requester always wins
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_id    = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;
        sel_a       = grant_id ? bus.req1_a  : bus.req0_a;
        sel_b       = grant_id ? bus.req1_b  : bus.req0_b;
        sel_op      = grant_id ? bus.req1_op : bus.req0_op;
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic sel_illegal;
    logic rsp_err_q;

    assign sel_illegal = (sel_op[1:0] == 2'b11);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                accept         = grant_valid;
                bus.req0_ready = grant_valid & ~grant_id;
                bus.req1_ready = grant_valid &  grant_id;
                if (grant_valid) begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    state_next = sel_illegal ? RESP : EXEC;
`else
                    state_next = EXEC;
`endif
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand registers feed the ALU in every state, so its inputs only move on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            prio    <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_ctrl <= 3'b000;
            op_id   <= 1'b0;
        end else if (accept) begin
            prio    <= ~grant_id;
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_ctrl <= sel_op;
            op_id   <= grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            rsp_err_q    <= 1'b0;
`endif
        end else if (state == EXEC) begin
            rsp_id_q     <= op_id;
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            rsp_err_q    <= 1'b0;
        end else if (accept && sel_illegal) begin
            rsp_id_q     <= grant_id;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b1;
`endif
        end
    end

    assign alu_srcA       = op_a;
    assign alu_srcB       = op_b;
    assign alu_ctrl       = op_ctrl;

    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign bus.rsp_err    = rsp_err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ALU attached to its ALU port.
// Honours ALU_ARB_ILLEGAL_OP_EN when choosing expected latency and error flag.
module tb_alu_arbiter;

    localparam int DATA_W = 32;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    localparam bit ILLEGAL_EN = 1'b1;
`else
    localparam bit ILLEGAL_EN = 1'b0;
`endif

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] alu_srcA;
    logic [DATA_W-1:0] alu_srcB;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    int   tests = 0;
    int   fails = 0;
    logic model_prio;
    rsp_t sb[$];

    alu_arbiter_if #(.DATA_W(DATA_W)) bus();

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_srcA   (alu_srcA),
        .alu_srcB   (alu_srcB),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return a - b;
            3'b101:  return a * b;
            3'b110:  return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic zero_fn(input logic [2:0] op, input logic [31:0] result);
        return (op[1:0] == 2'b11) ? 1'b0 : (result == 32'd0);
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_srcA, alu_srcB, alu_ctrl);
        alu_zero   = zero_fn(alu_ctrl, alu_result);
    end

    function automatic rsp_t expected(input logic id, input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op);
        rsp_t r;
        r.id     = id;
        r.result = alu_fn(a, b, op);
        r.zero   = zero_fn(op, r.result);
        r.err    = 1'b0;
        if (ILLEGAL_EN && op[1:0] == 2'b11) begin
            r.result = 32'd0;
            r.zero   = 1'b0;
            r.err    = 1'b1;
        end
        return r;
    endfunction

    function automatic logic rdy(input logic id);
        return id ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] required);
        tests++;
        assert (observed === required)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, required);
        end
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] op);
        if (id) begin
            bus.req1_valid = v;
            bus.req1_a     = a;
            bus.req1_b     = b;
            bus.req1_op    = op;
        end else begin
            bus.req0_valid = v;
            bus.req0_a     = a;
            bus.req0_b     = b;
            bus.req0_op    = op;
        end
    endtask

    // Presents one request while the arbiter is idle and lets it be accepted at the next edge
    task automatic apply_stimulus(input logic id, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, input bit keep_valid);
        drive_req(id, 1'b1, a, b, op);
        #1;
        check_output("grant_ready", 32'(rdy(id)), 32'd1);
        check_output("other_ready", 32'(rdy(~id)), 32'd0);
        sb.push_back(expected(id, a, b, op));
        model_prio = ~id;
        tick();
        if (!keep_valid) drive_req(id, 1'b0, a, b, op);
    endtask

    task automatic check_response(output rsp_t e);
        e = '{id: 1'b0, result: 32'd0, zero: 1'b0, err: 1'b0};
        check_output("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_output("resp_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        if (sb.size() == 0) begin
            check_output("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check_output("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check_output("rsp_result", bus.rsp_result, e.result);
            check_output("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
            check_output("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        end
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
        rsp_t e;
        apply_stimulus(id, a, b, op, 1'b0);
        if (!(ILLEGAL_EN && op[1:0] == 2'b11)) begin
            check_output("exec_no_valid", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        check_response(e);
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_prio = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rsp_t e;
        rsp_t held;

        reset         = 1'b1;
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        drive_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b000);
        apply_reset();

        check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check_output("reset_rsp_result", bus.rsp_result, 32'd0);
        check_output("reset_rsp_zero", 32'(bus.rsp_zero), 32'd0);
        check_output("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_output("reset_srcA", alu_srcA, 32'd0);
        check_output("reset_srcB", alu_srcB, 32'd0);
        check_output("reset_ctrl", 32'(alu_ctrl), 32'd0);

        bus.rsp_ready = 1'b1;
        run_op(1'b0, 32'd5, 32'd7, 3'b010);
        run_op(1'b1, 32'd3, 32'd3, 3'b100);
        run_op(1'b1, 32'd9, 32'd2, 3'b110);
        run_op(1'b0, 32'd2, 32'd9, 3'b110);
        run_op(1'b1, 32'd6, 32'd7, 3'b101);
        run_op(1'b0, 32'hF0, 32'h0F, 3'b000);
        // prio now points at requester 1, but a lone requester 0 must still win
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010);

        // Contention from reset: grants alternate 0,1,0,1 with a response every 3 cycles
        apply_reset();
        drive_req(1'b0, 1'b1, 32'hF0, 32'h0F, 3'b001);
        drive_req(1'b1, 1'b1, 32'h10, 32'h03, 3'b100);
        for (int k = 0; k < 4; k++) begin
            logic        g;
            logic [31:0] a;
            logic [31:0] b;
            logic [2:0]  op;
            g  = model_prio;
            a  = g ? bus.req1_a  : bus.req0_a;
            b  = g ? bus.req1_b  : bus.req0_b;
            op = g ? bus.req1_op : bus.req0_op;
            check_output("cont_order", 32'(g), 32'(k % 2));
            apply_stimulus(g, a, b, op, 1'b1);
            drive_req(g, 1'b1, a + 32'd1, b, op);
            check_output("cont_exec_valid", 32'(bus.rsp_valid), 32'd0);
            check_output("cont_exec_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
            tick();
            check_response(e);
            tick();
        end

        // Backpressure: response held for 5 cycles while the other requester waits
        bus.rsp_ready = 1'b0;
        begin
            logic g;
            g = model_prio;
            apply_stimulus(g, 32'd100, 32'd1, 3'b100, 1'b1);
            tick();
            check_response(held);
            for (int k = 0; k < 5; k++) begin
                tick();
                check_output("bp_valid", 32'(bus.rsp_valid), 32'd1);
                check_output("bp_result", bus.rsp_result, held.result);
                check_output("bp_id", 32'(bus.rsp_id), 32'(held.id));
                check_output("bp_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
            end
            bus.rsp_ready = 1'b1;
            tick();
            check_output("bp_released", 32'(bus.rsp_valid), 32'd0);
            check_output("bp_next_grant", 32'(rdy(~g)), 32'd1);
            drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
            drive_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b000);
            tick();
        end

        // Reset in the cycle after acceptance discards the operation
        run_op(1'b0, 32'd1, 32'd1, 3'b010);
        apply_stimulus(1'b0, 32'd4, 32'd4, 3'b010, 1'b0);
        void'(sb.pop_back());
        reset = 1'b1;
        tick();
        check_output("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("rst_mid_ctrl", 32'(alu_ctrl), 32'd0);
        check_output("rst_mid_srcA", alu_srcA, 32'd0);
        reset = 1'b0;
        model_prio = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        drive_req(1'b0, 1'b1, 32'd8, 32'd8, 3'b010);
        drive_req(1'b1, 1'b1, 32'd1, 32'd2, 3'b010);
        #1;
        check_output("rst_prio_req0", 32'(bus.req0_ready), 32'd1);
        check_output("rst_prio_req1", 32'(bus.req1_ready), 32'd0);
        drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        drive_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b000);
        tick();

        // Illegal opcodes: short path and error flag only with the feature enabled
        run_op(1'b0, 32'd1, 32'd1, 3'b111);
        run_op(1'b1, 32'd5, 32'd5, 3'b011);
        run_op(1'b0, 32'd20, 32'd22, 3'b010);

        check_output("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
